// File: rtl/sram_stream_pkg.sv
// ---------------------------------------------------------------------------
// sram_stream_pkg
// Shared definitions for the SRAM stream reader: the default bus widths and
// the reader FSM state type.
// ---------------------------------------------------------------------------
package sram_stream_pkg;

    localparam int ADDR_WIDTH = 4;   // 16-word memory
    localparam int DATA_WIDTH = 32;  // word width
    localparam int CNT_WIDTH  = 5;   // burst length 0..31

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

endpackage : sram_stream_pkg

// File: rtl/sram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// sram_stream_reader_if
// Bundles the burst-request handshake, the memory read port and the output
// stream of the SRAM stream reader.
//   slave  : the reader itself (accepts requests, drives memory address and
//            the output stream).
//   master : the surrounding system (issues requests, returns memory data,
//            sinks the stream).
// ---------------------------------------------------------------------------
interface sram_stream_reader_if #(
    parameter int ADDR_WIDTH = sram_stream_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_stream_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = sram_stream_pkg::CNT_WIDTH
);
    // burst request
    logic                  startValid;
    logic                  startReady;
    logic [ADDR_WIDTH-1:0] startAddress;
    logic [CNT_WIDTH-1:0]  wordCount;
    logic                  abort;
    // memory read port (asynchronous read)
    logic [ADDR_WIDTH-1:0] memReadAddress;
    logic [DATA_WIDTH-1:0] memReadData;
    // output stream
    logic                  dataValid;
    logic                  dataReady;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  dataLast;
    // status
    logic                  busy;

    modport slave (
        input  startValid, startAddress, wordCount, abort, memReadData, dataReady,
        output startReady, memReadAddress, dataValid, dataOut, dataLast, busy
    );

    modport master (
        output startValid, startAddress, wordCount, abort, memReadData, dataReady,
        input  startReady, memReadAddress, dataValid, dataOut, dataLast, busy
    );

endinterface : sram_stream_reader_if

// File: rtl/sram_stream_reader.sv
// ---------------------------------------------------------------------------
// sram_stream_reader
// Streams a burst of words out of an external asynchronous-read memory.
// A request (start address, word count) is taken in IDLE; one FETCH cycle
// primes the output register, then STREAM delivers one word per accepted
// transfer with valid/ready back-pressure. Addresses wrap modulo memory size.
//
// Ports
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : sram_stream_reader_if.slave (request, memory port, stream, busy)
// ---------------------------------------------------------------------------
module sram_stream_reader #(
    parameter int ADDR_WIDTH = sram_stream_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_stream_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = sram_stream_pkg::CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    sram_stream_reader_if.slave  bus
);
    import sram_stream_pkg::*;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;   // words still to be transferred, incl. current
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [CNT_WIDTH-1:0]  w_remaining_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_valid_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_remaining <= w_remaining_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_remaining_next = r_remaining;
        w_data_next      = r_data;
        w_valid_next     = r_valid;

        case (r_state)
            ST_IDLE: begin
                // abort is ignored here; a zero-length request is simply consumed
                if (bus.startValid && (bus.wordCount != '0)) begin
                    w_addr_next      = bus.startAddress;
                    w_remaining_next = bus.wordCount;
                    w_state_next     = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (bus.abort) begin
                    w_valid_next     = 1'b0;
                    w_remaining_next = '0;
                    w_state_next     = ST_IDLE;
                end else begin
                    w_data_next  = bus.memReadData;
                    w_valid_next = 1'b1;
                    w_addr_next  = r_addr + ADDR_WIDTH'(1);
                    w_state_next = ST_STREAM;
                end
            end

            ST_STREAM: begin
                // abort wins over a transfer in the same cycle
                if (bus.abort) begin
                    w_valid_next     = 1'b0;
                    w_remaining_next = '0;
                    w_state_next     = ST_IDLE;
                end else if (r_valid && bus.dataReady) begin
                    if (r_remaining > CNT_WIDTH'(1)) begin
                        // memory already points at the next word, capture it now
                        w_data_next      = bus.memReadData;
                        w_addr_next      = r_addr + ADDR_WIDTH'(1);
                        w_remaining_next = r_remaining - CNT_WIDTH'(1);
                    end else begin
                        w_valid_next     = 1'b0;
                        w_remaining_next = '0;
                        w_state_next     = ST_IDLE;
                    end
                end
            end

            default: begin
                w_valid_next     = 1'b0;
                w_remaining_next = '0;
                w_state_next     = ST_IDLE;
            end
        endcase
    end

    assign bus.startReady     = (r_state == ST_IDLE);
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.memReadAddress = r_addr;
    assign bus.dataOut        = r_data;
    assign bus.dataValid      = r_valid;
    assign bus.dataLast       = r_valid && (r_remaining == CNT_WIDTH'(1));

endmodule : sram_stream_reader

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameters: ADDR_WIDTH, default 4, memory address width (16 words); DATA_WIDTH, default 32, word width; CNT_WIDTH, default 5, burst length width.
REQ-002 clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces all registers to reset values immediately.
REQ-004 startValid  in  1  burst request valid.
REQ-005 startReady  out  1  reader idle, able to accept a burst request.
REQ-006 startAddress  in  ADDR_WIDTH  first word address of burst.
REQ-007 wordCount  in  CNT_WIDTH  number of words to stream, 0..31.
REQ-008 abort  in  1  terminate current burst.
REQ-009 memReadAddress  out  ADDR_WIDTH  registered address to the asynchronous-read port of the 16x32 dual-port memory.
REQ-010 memReadData  in  DATA_WIDTH  combinational read data returned for memReadAddress.
REQ-011 dataValid  out  1  dataOut holds a valid word.
REQ-012 dataReady  in  1  sink accepts word.
REQ-013 dataOut  out  DATA_WIDTH  registered streamed word.
REQ-014 dataLast  out  1  dataOut is the final word of the burst.
REQ-015 busy  out  1  burst in progress (state not IDLE).

Function
REQ-016 FSM states IDLE, FETCH, STREAM; startReady SHALL be 1 only in IDLE.
REQ-017 Burst accepted at an edge where startValid&startReady; if wordCount!=0, memReadAddress<=startAddress, remaining<=wordCount, state->FETCH.
REQ-018 Accepted request with wordCount==0 SHALL be consumed with no data output, state stays IDLE.
REQ-019 FETCH (one cycle): dataOut<=memReadData, dataValid<=1, memReadAddress<=memReadAddress+1 mod 16, state->STREAM; first word valid on the 2nd edge after acceptance.
REQ-020 STREAM: a transfer occurs at an edge where dataValid&dataReady; dataOut/dataValid SHALL hold stable while dataValid&!dataReady.
REQ-021 On transfer with remaining>1: dataOut<=memReadData, memReadAddress increments mod 16, remaining decrements; sustained throughput one word per cycle.
REQ-022 On transfer with remaining==1: dataValid<=0, state->IDLE, startReady<=1.
REQ-023 dataLast SHALL equal dataValid&&(remaining==1).
REQ-024 Address wrap: 15 SHALL increment to 0; wordCount>16 rereads words modulo 16.
REQ-025 Word contents SHALL be those present in memory at the capture edge; concurrent writes to not-yet-captured addresses are visible.
REQ-026 abort in FETCH or STREAM SHALL, at next edge, force IDLE, dataValid<=0, startReady<=1, and take priority over a simultaneous transfer (word not counted); abort in IDLE has no effect and does not block a simultaneous start.
REQ-027 busy SHALL be 1 in FETCH and STREAM, 0 in IDLE.

Reset
REQ-028 On reset: state IDLE, startReady 1, dataValid 0, dataOut 0, memReadAddress 0, remaining 0, busy 0, dataLast 0.
REQ-029 Reset asserted mid-burst SHALL discard the burst immediately, with no further transfers after release until a new start.

Structure
REQ-030 Shared package sram_stream_pkg SHALL hold the FSM state type and default width constants (ADDR_WIDTH, DATA_WIDTH, CNT_WIDTH).
REQ-031 No sub-module; the memory is instantiated by the parent and connected via memReadAddress/memReadData.

Verification
REQ-032 Preload mem[i]=0xA000_0000+i; start addr 3, count 4, dataReady=1 -> words A0000003..A0000006 on consecutive cycles, dataLast on the 4th, then startReady=1.
REQ-033 Start addr 14, count 4 -> addresses 14,15,0,1 streamed; count 20 from addr 0 -> words 0..15,0..3.
REQ-034 Back-pressure: dataReady toggled 1,0,0,1,... -> dataOut stable while stalled, no word lost or duplicated, order preserved.
REQ-035 abort asserted in same cycle as 2nd transfer of count-8 burst -> dataValid 0 next cycle, only 1 word counted delivered, new start accepted next cycle.
REQ-036 count 0 start -> no dataValid, startReady stays 1; reset asserted mid-burst -> all outputs at reset values asynchronously, no transfer after release.
